// File: rtl/cpu_pkg.sv
// cpu_pkg: shared instruction-cache parameters, state encoding and address-field helpers
package cpu_pkg;

    localparam int ICACHE_INDEX_BITS = 6;

    typedef enum logic {
        IC_IDLE,
        IC_MISS
    } icache_state_e;

    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int index_bits);
        return (pc >> 2) & ((32'd1 << index_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int index_bits);
        return pc >> (index_bits + 2);
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: valid/tag/data arrays with combinational read and synchronous write
module icache_line_store #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [31:0]           wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tags [LINES];
    logic [31:0]         data [LINES];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index];

    // Valid bits are the only reset state; a fill marks its line valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            valid <= '0;
        else if (wr_en)
            valid[wr_index] <= 1'b1;
    end

    // Tag and data payload, never reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_data;
        end
    end

endmodule

// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped one-word-per-line cache with single outstanding miss
module instruction_cache
    import cpu_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic        flush,
    output logic        fetch_ready,
    output logic [31:0] fetch_ins,
    output logic        ic_flag,
    output logic [31:0] ins_addr,
    input  logic [31:0] ins,
    input  logic        ins_rdy
);

    localparam int TAG_BITS = 30 - INDEX_BITS;

    icache_state_e         state;
    logic                  discard;
    logic [INDEX_BITS-1:0] miss_index;
    logic [TAG_BITS-1:0]   miss_tag;
    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  line_valid;
    logic [TAG_BITS-1:0]   line_tag;
    logic [31:0]           line_data;
    logic                  hit;
    logic                  fill;

    assign req_index = INDEX_BITS'(pc_index(fetch_pc, INDEX_BITS));
    assign req_tag   = TAG_BITS'(pc_tag(fetch_pc, INDEX_BITS));
    assign hit       = line_valid && (line_tag == req_tag);
    assign fill      = rdy && (state == IC_MISS) && ins_rdy;

    icache_line_store #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .rd_index(req_index),
        .rd_valid(line_valid),
        .rd_tag  (line_tag),
        .rd_data (line_data),
        .wr_en   (fill),
        .wr_index(miss_index),
        .wr_tag  (miss_tag),
        .wr_data (ins)
    );

    // Lookup/miss FSM; fetch_ready and ic_flag are single-cycle pulses, all frozen while rdy is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IC_IDLE;
            discard     <= 1'b0;
            fetch_ready <= 1'b0;
            fetch_ins   <= '0;
            ic_flag     <= 1'b0;
            ins_addr    <= '0;
            miss_index  <= '0;
            miss_tag    <= '0;
        end else if (rdy) begin
            fetch_ready <= 1'b0;
            ic_flag     <= 1'b0;
            case (state)
                IC_IDLE: begin
                    if (fetch_valid && !fetch_ready && !flush) begin
                        if (hit) begin
                            fetch_ins   <= line_data;
                            fetch_ready <= 1'b1;
                        end else begin
                            ins_addr   <= {fetch_pc[31:2], 2'b00};
                            ic_flag    <= 1'b1;
                            miss_index <= req_index;
                            miss_tag   <= req_tag;
                            state      <= IC_MISS;
                        end
                    end
                end
                IC_MISS: begin
                    if (flush)
                        discard <= 1'b1;
                    if (ins_rdy) begin
                        if (!discard && !flush) begin
                            fetch_ins   <= ins;
                            fetch_ready <= 1'b1;
                        end
                        discard <= 1'b0;
                        state   <= IC_IDLE;
                    end
                end
                default: state <= IC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// tb_instruction_cache: randomized self-checking bench against a word-address cache model
module tb_instruction_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        flush = 1'b0;
    logic        fetch_ready;
    logic [31:0] fetch_ins;
    logic        ic_flag;
    logic [31:0] ins_addr;
    logic [31:0] ins = '0;
    logic        ins_rdy = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic        model_valid [64];
    logic [31:0] model_addr  [64];

    instruction_cache dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .fetch_valid(fetch_valid),
        .fetch_pc   (fetch_pc),
        .flush      (flush),
        .fetch_ready(fetch_ready),
        .fetch_ins  (fetch_ins),
        .ic_flag    (ic_flag),
        .ins_addr   (ins_addr),
        .ins        (ins),
        .ins_rdy    (ins_rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (word_of(a) * 32'h9E37_79B1) ^ 32'h0000_0513;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 2) % 64);
    endfunction

    function automatic logic model_hit(input logic [31:0] a);
        return model_valid[line_of(a)] && model_addr[line_of(a)] == word_of(a);
    endfunction

    task automatic model_fill(input logic [31:0] a);
        model_valid[line_of(a)] = 1'b1;
        model_addr[line_of(a)]  = word_of(a);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        model_clear();
    endtask

    // Issues one request and plays memory controller for a resulting miss; reports what was seen
    task automatic fetch_txn(input logic [31:0] a, output logic flagged, output logic delivered,
                             output logic [31:0] seen_addr, output logic [31:0] data);
        flagged = 1'b0; delivered = 1'b0; seen_addr = '0; data = '0;
        fetch_valid = 1'b1; fetch_pc = a;
        tick();
        fetch_valid = 1'b0;
        if (fetch_ready) begin
            delivered = 1'b1; data = fetch_ins;
        end else if (ic_flag) begin
            flagged = 1'b1; seen_addr = ins_addr;
            repeat ($urandom_range(5, 8)) tick();
            ins = mem_word(seen_addr); ins_rdy = 1'b1;
            tick();
            ins_rdy = 1'b0;
            if (fetch_ready) begin
                delivered = 1'b1; data = fetch_ins;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_ready got %b want 0", fetch_ready); end
        n_checks++; if (fetch_ins !== 32'h0) begin n_fail++; $display("FAIL reset_fetch_ins got %h want 0", fetch_ins); end
        n_checks++; if (ic_flag !== 1'b0) begin n_fail++; $display("FAIL reset_ic_flag got %b want 0", ic_flag); end
        n_checks++; if (ins_addr !== 32'h0) begin n_fail++; $display("FAIL reset_ins_addr got %h want 0", ins_addr); end
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        tick();
    endtask

    task automatic test_cold_miss();
        logic f, d;
        logic [31:0] sa, dat;
        fetch_txn(32'h0, f, d, sa, dat);
        n_checks++; if (f !== 1'b1) begin n_fail++; $display("FAIL cold_flag got %b want 1", f); end
        n_checks++; if (sa !== 32'h0) begin n_fail++; $display("FAIL cold_ins_addr got %h want 0", sa); end
        n_checks++; if (d !== 1'b1) begin n_fail++; $display("FAIL cold_delivered got %b want 1", d); end
        n_checks++; if (dat !== 32'h0000_0513) begin n_fail++; $display("FAIL cold_data got %h want 00000513", dat); end
        model_fill(32'h0);
    endtask

    task automatic test_warm_hit();
        logic f, d;
        logic [31:0] sa, dat;
        logic [2:0] pattern;
        fetch_txn(32'h2, f, d, sa, dat);
        n_checks++; if (f !== 1'b0) begin n_fail++; $display("FAIL warm_flag got %b want 0", f); end
        n_checks++; if (d !== 1'b1) begin n_fail++; $display("FAIL warm_delivered got %b want 1", d); end
        n_checks++; if (dat !== mem_word(32'h0)) begin n_fail++; $display("FAIL warm_data got %h want %h", dat, mem_word(32'h0)); end
        fetch_valid = 1'b1; fetch_pc = 32'h0;
        tick(); pattern[2] = fetch_ready;
        tick(); pattern[1] = fetch_ready;
        tick(); pattern[0] = fetch_ready;
        fetch_valid = 1'b0;
        tick();
        n_checks++; if (pattern !== 3'b101) begin n_fail++; $display("FAIL held_request_ready got %b want 101", pattern); end
    endtask

    task automatic test_conflict();
        logic f, d;
        logic [31:0] sa, dat;
        logic [31:0] seq [3];
        int flags;
        seq[0] = 32'h0; seq[1] = 32'h100; seq[2] = 32'h0;
        apply_reset();
        flags = 0;
        for (int i = 0; i < 3; i++) begin
            fetch_txn(seq[i], f, d, sa, dat);
            flags += int'(f);
            model_fill(seq[i]);
            n_checks++; if (dat !== mem_word(seq[i])) begin n_fail++; $display("FAIL conflict_data[%0d] got %h want %h", i, dat, mem_word(seq[i])); end
        end
        n_checks++; if (flags !== 3) begin n_fail++; $display("FAIL conflict_flag_count got %0d want 3", flags); end
    endtask

    task automatic test_flush_miss();
        logic f, d;
        logic [31:0] sa, dat;
        logic seen;
        fetch_valid = 1'b1; fetch_pc = 32'h40;
        tick();
        fetch_valid = 1'b0;
        n_checks++; if (ic_flag !== 1'b1) begin n_fail++; $display("FAIL flush_miss_flag got %b want 1", ic_flag); end
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        seen = fetch_ready;
        repeat (4) begin tick(); seen |= fetch_ready; end
        ins = mem_word(32'h40); ins_rdy = 1'b1;
        tick();
        ins_rdy = 1'b0;
        seen |= fetch_ready;
        tick();
        seen |= fetch_ready;
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_miss_no_delivery got %b want 0", seen); end
        model_fill(32'h40);
        fetch_txn(32'h40, f, d, sa, dat);
        n_checks++; if (f !== 1'b0) begin n_fail++; $display("FAIL flush_refetch_flag got %b want 0", f); end
        n_checks++; if (dat !== mem_word(32'h40)) begin n_fail++; $display("FAIL flush_refetch_data got %h want %h", dat, mem_word(32'h40)); end
    endtask

    task automatic test_flush_coincident();
        logic f, d;
        logic [31:0] sa, dat;
        fetch_valid = 1'b1; fetch_pc = 32'h80;
        tick();
        fetch_valid = 1'b0;
        n_checks++; if (ic_flag !== 1'b1) begin n_fail++; $display("FAIL coinc_flag got %b want 1", ic_flag); end
        repeat (5) tick();
        ins = mem_word(32'h80); ins_rdy = 1'b1; flush = 1'b1;
        tick();
        ins_rdy = 1'b0; flush = 1'b0;
        n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL coinc_no_delivery got %b want 0", fetch_ready); end
        tick();
        model_fill(32'h80);
        fetch_txn(32'h80, f, d, sa, dat);
        n_checks++; if ({f, d} !== 2'b01) begin n_fail++; $display("FAIL coinc_refetch_hit got flag=%b ready=%b want flag=0 ready=1", f, d); end
        n_checks++; if (dat !== mem_word(32'h80)) begin n_fail++; $display("FAIL coinc_refetch_data got %h want %h", dat, mem_word(32'h80)); end
    endtask

    task automatic test_rdy_low();
        fetch_valid = 1'b1; fetch_pc = 32'hC3;
        tick();
        fetch_valid = 1'b0;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ins = 32'hDEAD_BEEF; ins_rdy = (i == 1);
            tick();
            ins_rdy = 1'b0;
            n_checks++; if ({ic_flag, fetch_ready} !== 2'b10) begin n_fail++; $display("FAIL rdy_low_flags[%0d] got flag=%b ready=%b want flag=1 ready=0", i, ic_flag, fetch_ready); end
            n_checks++; if (ins_addr !== 32'hC0) begin n_fail++; $display("FAIL rdy_low_ins_addr[%0d] got %h want 000000c0", i, ins_addr); end
        end
        rdy = 1'b1;
        tick();
        n_checks++; if ({ic_flag, fetch_ready} !== 2'b00) begin n_fail++; $display("FAIL rdy_resume_flags got flag=%b ready=%b want 0 0", ic_flag, fetch_ready); end
        repeat (4) tick();
        ins = mem_word(32'hC0); ins_rdy = 1'b1;
        tick();
        ins_rdy = 1'b0;
        n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL rdy_resume_ready got %b want 1", fetch_ready); end
        n_checks++; if (fetch_ins !== mem_word(32'hC0)) begin n_fail++; $display("FAIL rdy_resume_data got %h want %h", fetch_ins, mem_word(32'hC0)); end
        tick();
        model_fill(32'hC0);
    endtask

    task automatic test_async_reset();
        logic f, d;
        logic [31:0] sa, dat;
        fetch_valid = 1'b1; fetch_pc = 32'h1C0;
        tick();
        fetch_valid = 1'b0;
        n_checks++; if (ic_flag !== 1'b1) begin n_fail++; $display("FAIL areset_pre_flag got %b want 1", ic_flag); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if ({ic_flag, fetch_ready} !== 2'b00) begin n_fail++; $display("FAIL areset_flags got flag=%b ready=%b want 0 0", ic_flag, fetch_ready); end
        n_checks++; if (ins_addr !== 32'h0 || fetch_ins !== 32'h0) begin n_fail++; $display("FAIL areset_regs got addr=%h ins=%h want 0 0", ins_addr, fetch_ins); end
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        tick();
        fetch_txn(32'h0, f, d, sa, dat);
        n_checks++; if (f !== 1'b1) begin n_fail++; $display("FAIL areset_refetch_flag got %b want 1", f); end
        n_checks++; if (dat !== mem_word(32'h0)) begin n_fail++; $display("FAIL areset_refetch_data got %h want %h", dat, mem_word(32'h0)); end
        model_fill(32'h0);
    endtask

    task automatic test_random();
        logic f, d, exp_hit;
        logic [31:0] sa, dat, a;
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            exp_hit = model_hit(a);
            fetch_txn(a, f, d, sa, dat);
            n_checks++; if (f !== !exp_hit) begin n_fail++; $display("FAIL rand_flag[%0d] addr=%h got %b want %b", i, a, f, !exp_hit); end
            n_checks++; if (d !== 1'b1 || dat !== mem_word(a)) begin n_fail++; $display("FAIL rand_data[%0d] addr=%h got ready=%b data=%h want 1 %h", i, a, d, dat, mem_word(a)); end
            if (!exp_hit) begin
                n_checks++; if (sa !== word_of(a)) begin n_fail++; $display("FAIL rand_ins_addr[%0d] got %h want %h", i, sa, word_of(a)); end
            end
            model_fill(a);
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        model_clear();
        #1;
        test_reset();
        test_cold_miss();
        test_warm_hit();
        test_conflict();
        test_flush_miss();
        test_flush_coincident();
        test_rdy_low();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
